// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the stream destination router:
//   - DATA_W    : payload byte width
//   - dest_e    : destination select codes driven on m_sel
//   - state_e   : router FSM states
//   - dest_is_valid() : classifies a header byte as routable or not
// ---------------------------------------------------------------------------
package stream_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    DEST_NONE = 3'd0,
    DEST_M1   = 3'd1,
    DEST_M2   = 3'd2,
    DEST_S1   = 3'd3,
    DEST_S2   = 3'd4,
    DEST_S3   = 3'd5
  } dest_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // The whole header byte is the code: only 1..5 name an endpoint, every
  // other value (0, 6, 7 and anything above) is treated as undeliverable.
  function automatic logic dest_is_valid(input logic [DATA_W-1:0] code);
    return (code >= 8'd1) && (code <= 8'd5);
  endfunction

endpackage

// File: rtl/stream_dest_router_if.sv
// ---------------------------------------------------------------------------
// stream_dest_router_if
// Bundles the upstream byte stream (s_*) and the downstream stream towards
// the endpoint mux (m_*, m_sel).
//   master : view of the router (drives s_tready and all m_* outputs)
//   slave  : view of the surrounding environment (source + mux)
// ---------------------------------------------------------------------------
interface stream_dest_router_if;
  import stream_pkg::*;

  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [2:0]        m_sel;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_sel, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_sel, m_tdata, m_tvalid, m_tlast
  );

endinterface

// File: rtl/stream_reg_slice.sv
// ---------------------------------------------------------------------------
// stream_reg_slice
// One-entry valid/ready register for a byte + last flag. Accepts a new beat
// whenever it is empty or its current beat leaves in the same cycle, so a
// continuous stream passes at one beat per cycle with one cycle of latency.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_data/in_last       : incoming beat
//   in_valid/in_ready     : input handshake
//   out_data/out_last     : registered beat
//   out_valid/out_ready   : output handshake
// ---------------------------------------------------------------------------
module stream_reg_slice
  import stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

  // Next-state for the holding register: load, drain, or hold.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (in_valid && in_ready) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end else if (out_ready) begin
      // Data/last are left as-is; only valid drops once the beat is taken.
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/stream_dest_router.sv
// ---------------------------------------------------------------------------
// stream_dest_router
// Strips the header byte of each packet and forwards the payload to the
// endpoint named by that header (via m_sel). Packets with an unknown code
// are swallowed and counted; header-only packets to a valid code are
// silently discarded.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : stream_dest_router_if.master (s_* upstream, m_* downstream)
//   drop_cnt   : saturating count of packets with an invalid destination
//   busy       : high while a packet is in progress or a beat is pending
// Parameters:
//   CNT_W      : width of drop_cnt
// ---------------------------------------------------------------------------
module stream_dest_router
  import stream_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_dest_router_if.master  bus,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s_tready_s;
  logic              slice_in_valid_s;
  logic              slice_in_ready_s;
  logic [DATA_W-1:0] m_tdata_s;
  logic              m_tvalid_s;
  logic              m_tlast_s;
  logic              out_done_s;

  stream_reg_slice u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bus.s_tdata),
    .in_last   (bus.s_tlast),
    .in_valid  (slice_in_valid_s),
    .in_ready  (slice_in_ready_s),
    .out_data  (m_tdata_s),
    .out_last  (m_tlast_s),
    .out_valid (m_tvalid_s),
    .out_ready (bus.m_tready)
  );

  assign out_done_s   = m_tvalid_s && bus.m_tready && m_tlast_s;

  assign bus.s_tready = s_tready_s;
  assign bus.m_sel    = sel_q;
  assign bus.m_tdata  = m_tdata_s;
  assign bus.m_tvalid = m_tvalid_s;
  assign bus.m_tlast  = m_tlast_s;
  assign drop_cnt     = cnt_q;
  assign busy         = (state_q != ST_IDLE) || m_tvalid_s;

  // FSM next-state, upstream ready, destination select and drop counter.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    s_tready_s       = 1'b0;
    slice_in_valid_s = 1'b0;

    // The select is released once the final beat of a packet leaves; a new
    // header can only be taken after that, so the two never collide.
    if (out_done_s) begin
      sel_d = DEST_NONE;
    end else begin
      sel_d = sel_q;
    end

    case (state_q)
      ST_IDLE: begin
        // Waiting for the previous packet's tail keeps m_sel from changing
        // under a beat that is still in the output register.
        s_tready_s = !m_tvalid_s;
        if (bus.s_tvalid && s_tready_s) begin
          if (dest_is_valid(bus.s_tdata)) begin
            if (!bus.s_tlast) begin
              sel_d   = bus.s_tdata[2:0];
              state_d = ST_FWD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            state_d = bus.s_tlast ? ST_IDLE : ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FWD: begin
        s_tready_s       = slice_in_ready_s;
        slice_in_valid_s = bus.s_tvalid;
        if (bus.s_tvalid && slice_in_ready_s && bus.s_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FWD;
        end
      end

      ST_DROP: begin
        s_tready_s = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, destination select and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= DEST_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_dest_router.sv
// ---------------------------------------------------------------------------
// tb_stream_dest_router
// Scoreboard bench: expected payload beats are queued as packets are driven,
// downstream handshakes are captured, and each scenario task compares them.
// ---------------------------------------------------------------------------
module tb_stream_dest_router;
  import stream_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  stream_dest_router_if bus();

  stream_dest_router #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Entries are {sel[2:0], data[7:0], last}.
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int          obs_cyc[$];

  int          cycle        = 0;
  int          stall_viol   = 0;
  int          valid_cycles = 0;
  int          ready_mode   = 0;
  logic        prev_stall   = 1'b0;
  logic [7:0]  prev_data    = 8'h00;
  logic        prev_last    = 1'b0;

  // Downstream ready: always 1, or the repeating 1,0,0 stall pattern.
  initial begin
    int k;
    k = 0;
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        bus.m_tready = 1'b1;
      end else begin
        bus.m_tready = ((k % 3) == 0);
        k++;
      end
    end
  end

  // Capture downstream handshakes and track stall stability.
  always @(negedge clk) begin
    cycle <= cycle + 1;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_data ||
                         bus.m_tlast !== prev_last))
        stall_viol <= stall_viol + 1;
      if (bus.m_tvalid === 1'b1)
        valid_cycles <= valid_cycles + 1;
      if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
        obs_q.push_back({bus.m_sel, bus.m_tdata, bus.m_tlast});
        obs_cyc.push_back(cycle);
      end
      prev_stall <= (bus.m_tvalid === 1'b1) && (bus.m_tready === 1'b0);
      prev_data  <= bus.m_tdata;
      prev_last  <= bus.m_tlast;
    end
  end

  // Drives one upstream beat and waits (bounded) for it to be accepted.
  // Called and returns at posedge+1.
  task automatic send_beat(input logic [7:0] d, input logic l);
    bit done;
    done = 1'b0;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.s_tvalid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.s_tready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.s_tvalid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: beat %02h still not accepted, required acceptance within 64 cycles", d);
    end
  endtask

  // Sends header + payload; routable payload beats go to the scoreboard.
  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$]);
    logic lst;
    send_beat(hdr, pl.size() == 0);
    for (int i = 0; i < pl.size(); i++) begin
      lst = (i == pl.size() - 1);
      if (hdr >= 8'd1 && hdr <= 8'd5)
        exp_q.push_back({hdr[2:0], pl[i], lst});
      send_beat(pl[i], lst);
    end
  endtask

  // Waits (bounded) until the router is idle with an empty output register.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && bus.m_tvalid === 1'b0) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy=%0b m_tvalid=%0b, required both 0 within 200 cycles", busy, bus.m_tvalid);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++; if (bus.m_sel !== 3'd0) begin miscompares++; $display("FAIL rst_m_sel: got %0d, want 0", bus.m_sel); end
    vectors++; if (bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %0b, want 0", bus.m_tvalid); end
    vectors++; if (bus.m_tdata !== 8'h00) begin miscompares++; $display("FAIL rst_m_tdata: got %02h, want 00", bus.m_tdata); end
    vectors++; if (bus.m_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_m_tlast: got %0b, want 0", bus.m_tlast); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_drop_cnt: got %0d, want 0", drop_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b, want 0", busy); end
    vectors++; if (bus.s_tready !== 1'b1) begin miscompares++; $display("FAIL rst_s_tready: got %0b, want 1", bus.s_tready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0]  pl[$];
    logic [11:0] e, o;
    int          c[$];
    clear_sb();
    pl.push_back(8'hA1); pl.push_back(8'hA2); pl.push_back(8'hA3);
    send_pkt(8'h03, pl);
    wait_idle();
    c = obs_cyc;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL basic_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL basic_beat: got %03h, want %03h", o, e); end
    end
    vectors++;
    if (c.size() != 3 || c[1] != c[0] + 1 || c[2] != c[1] + 1) begin
      miscompares++;
      $display("FAIL basic_b2b: output beats not on consecutive cycles (%0d beats seen), want 3 consecutive", c.size());
    end
    vectors++; if (bus.m_sel !== 3'd0) begin miscompares++; $display("FAIL basic_sel_after: got %0d, want 0", bus.m_sel); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL basic_drop_cnt: got %0d, want 0", drop_cnt); end
  endtask

  task automatic test_stall();
    logic [7:0]  pl[$];
    logic [11:0] e, o;
    int          viol0;
    clear_sb();
    viol0 = stall_viol;
    ready_mode = 1;
    pl.push_back(8'hA1); pl.push_back(8'hA2); pl.push_back(8'hA3);
    send_pkt(8'h03, pl);
    wait_idle();
    ready_mode = 0;
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d beats, want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL stall_beat: got %03h, want %03h", o, e); end
    end
    vectors++;
    if (stall_viol != viol0) begin
      miscompares++;
      $display("FAIL stall_stable: got %0d unstable stall cycles, want 0", stall_viol - viol0);
    end
  endtask

  task automatic test_drop();
    logic [7:0] pl[$];
    int         v0;
    clear_sb();
    v0 = valid_cycles;
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33); pl.push_back(8'h44);
    send_pkt(8'h06, pl);
    wait_idle();
    vectors++; if (valid_cycles != v0) begin miscompares++; $display("FAIL drop_tvalid: got %0d valid cycles, want 0", valid_cycles - v0); end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL drop_out: got %0d beats, want 0", obs_q.size()); end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL drop_cnt: got %0d, want 1", drop_cnt); end
  endtask

  task automatic test_hdr_only();
    logic [7:0]  none[$];
    logic [7:0]  pl[$];
    logic [11:0] e, o;
    clear_sb();
    send_pkt(8'h01, none);
    pl.push_back(8'h55);
    send_pkt(8'h05, pl);
    wait_idle();
    vectors++;
    if (obs_q.size() != 1) begin
      miscompares++;
      $display("FAIL hdr_only_count: got %0d beats, want 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL hdr_only_beat: got %03h, want %03h", o, e); end
    end
    vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("FAIL hdr_only_cnt: got %0d, want 1", drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  p1[$];
    logic [7:0]  p2[$];
    logic [11:0] e, o;
    clear_sb();
    p1.push_back(8'hB1); p1.push_back(8'hB2);
    p2.push_back(8'hC1);
    send_pkt(8'h04, p1);
    send_pkt(8'h02, p2);
    wait_idle();
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d beats, want 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL b2b_beat: got %03h, want %03h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  pl[$];
    logic [11:0] e, o;
    clear_sb();
    send_beat(8'h02, 1'b0);
    send_beat(8'h5A, 1'b0);
    send_beat(8'h6B, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (bus.m_sel !== 3'd0) begin miscompares++; $display("FAIL mid_rst_sel: got %0d, want 0", bus.m_sel); end
    vectors++; if (bus.m_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tvalid: got %0b, want 0", bus.m_tvalid); end
    vectors++; if (bus.m_tdata !== 8'h00) begin miscompares++; $display("FAIL mid_rst_tdata: got %02h, want 00", bus.m_tdata); end
    vectors++; if (bus.m_tlast !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tlast: got %0b, want 0", bus.m_tlast); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %0b, want 0", busy); end
    vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_rst_cnt: got %0d, want 0", drop_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sb();
    pl.push_back(8'h77); pl.push_back(8'h78);
    send_pkt(8'h02, pl);
    wait_idle();
    vectors++;
    if (obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL mid_rst_count: got %0d beats, want 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      vectors++; if (o !== e) begin miscompares++; $display("FAIL mid_rst_beat: got %03h, want %03h", o, e); end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 255; i++) send_beat(8'h07, 1'b1);
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_255: got %0d, want 255", drop_cnt); end
    send_beat(8'h00, 1'b1);
    vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_hold: got %0d, want 255", drop_cnt); end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.s_tdata  = 8'h00;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_hdr_only();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at 500000, required completion earlier");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/stream_dest_router.md
STREAM_DEST_ROUTER -- requirements
Module: stream_dest_router

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of drop counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port s_tdata  input  8  upstream byte; first beat of each packet = destination code.
REQ-005 SHALL have port s_tvalid  input  1  upstream beat valid.
REQ-006 SHALL have port s_tlast  input  1  upstream last beat of packet.
REQ-007 SHALL have port s_tready  output  1  router accepts upstream beat.
REQ-008 SHALL have port m_sel  output  3  destination select to the endpoint mux (0 none, 1 master1, 2 master2, 3 slave1, 4 slave2, 5 slave3).
REQ-009 SHALL have port m_tdata  output  8  payload byte to mux.
REQ-010 SHALL have port m_tvalid  output  1  payload beat valid.
REQ-011 SHALL have port m_tlast  output  1  payload last beat.
REQ-012 SHALL have port m_tready  input  1  selected endpoint ready, returned by mux.
REQ-013 SHALL have port drop_cnt  output  CNT_W  count of dropped packets.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE or m_tvalid=1.

Function
REQ-015 SHALL implement FSM states IDLE, FWD, DROP.
REQ-016 IDLE: s_tready = !m_tvalid; header accepted only with output register empty.
REQ-017 IDLE header handshake, code 1..5, s_tlast=0: m_sel <= code, go FWD.
REQ-018 IDLE header handshake, code 1..5, s_tlast=1: header-only packet discarded, no output, no count, stay IDLE.
REQ-019 IDLE header handshake, code 0/6/7: drop_cnt += 1; s_tlast=1 -> stay IDLE, else -> DROP.
REQ-020 DROP: s_tready=1, beats discarded, m_* untouched; s_tlast handshake -> IDLE.
REQ-021 FWD: one-entry output register; s_tready = !m_tvalid || m_tready; accepted beat appears on m_tdata/m_tlast with m_tvalid=1 the next cycle (latency 1), sustaining 1 beat/cycle.
REQ-022 FWD: accepting beat with s_tlast=1 -> IDLE; no further upstream beat accepted until that last beat drains.
REQ-023 m_tdata, m_tlast, m_tvalid SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-024 m_sel SHALL change only on header acceptance, and return to 0 on the cycle after m_tvalid&m_tready&m_tlast.
REQ-025 Same-cycle output handshake and input accept in FWD SHALL reload the register without bubble.
REQ-026 drop_cnt SHALL saturate at 2^CNT_W-1.

Reset
REQ-027 On rst_n=0 (any time, including mid-packet): state IDLE, m_sel=0, m_tvalid=0, m_tdata=0, m_tlast=0, drop_cnt=0, busy=0, s_tready=1 after release; partial packet lost, no count.

Structure
REQ-028 Shared package stream_pkg SHALL hold destination codes (DEST_NONE=0 .. DEST_S3=5) and the FSM state enum.
REQ-029 Output register SHALL be a sub-module stream_reg_slice (8-bit data + last, valid/ready).

Verification
REQ-030 Header 0x03, payload 0xA1,0xA2,0xA3(last), m_tready=1 -> m_sel=3 throughout, three beats back-to-back, m_sel=0 after last, drop_cnt=0.
REQ-031 Same packet with m_tready toggled 1,0,0,1,... -> no beat lost/duplicated, m_tdata stable during stalls.
REQ-032 Header 0x06, 4 payload beats -> all consumed, m_tvalid never 1, drop_cnt=1.
REQ-033 Header 0x01 with s_tlast=1 then header 0x05 + 0x55(last) -> only 0x55 output, m_sel=5.
REQ-034 rst_n low after 2nd payload beat of dest 2 -> all outputs 0 within reset, next packet routed normally.
REQ-035 256 invalid header-only packets with CNT_W=8 -> drop_cnt=255.
